// File: rtl/gray_4bits.sv
// Free-running 4-bit Gray-code counter.
// A binary counter advances each clock; the output register holds the
// Gray encoding of the same next value, so both stay in step every cycle.
module gray_4bits (
  input  logic       clk,
  input  logic       reset,    // synchronous, active-low
  output logic [3:0] gray_out
);

  logic [3:0] bin_q, bin_d;
  logic [3:0] gray_q, gray_d;

  // Next-state: increment (wraps mod 16) and encode the incremented value.
  always_comb begin
    bin_d  = bin_q + 4'd1;
    gray_d = bin_d ^ (bin_d >> 1);
    if (!reset) begin
      bin_d  = 4'd0;
      gray_d = 4'd0;
    end
  end

  // State registers; reset is folded into the next-state logic above.
  always_ff @(posedge clk) begin
    bin_q  <= bin_d;
    gray_q <= gray_d;
  end

  assign gray_out = gray_q;

endmodule

// File: tb/tb_gray_4bits.sv
// Self-checking bench for gray_4bits using a queue-based scoreboard.
module tb_gray_4bits;

  logic       clk;
  logic       reset;
  logic [3:0] gray_out;

  gray_4bits dut (
    .clk      (clk),
    .reset    (reset),
    .gray_out (gray_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total_cnt = 0;
  int unsigned pass_cnt  = 0;

  logic [3:0] exp_q [$];
  logic [3:0] mdl_bin;
  logic [3:0] exp_v;
  logic [3:0] prev_v;
  logic [3:0] seq [16];

  function automatic logic [3:0] gray_of(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Two edges with reset low from an undefined state.
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset   = 1'b0;
      mdl_bin = 4'd0;
      exp_q.push_back(4'b0000);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (gray_out !== exp_v)
        $display("FAIL reset_edge%0d got %b want %b", i, gray_out, exp_v);
      else pass_cnt++;
    end
  endtask

  // Sixteen edges after release must follow the fixed reference sequence.
  task automatic test_full_cycle();
    prev_v = gray_out;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reset   = 1'b1;
      mdl_bin = mdl_bin + 4'd1;
      exp_q.push_back(seq[(i + 1) % 16]);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (gray_out !== exp_v)
        $display("FAIL full_cycle step%0d got %b want %b", i + 1, gray_out, exp_v);
      else pass_cnt++;
      total_cnt++;
      if ($countones(gray_out ^ prev_v) != 1)
        $display("FAIL full_cycle_onebit step%0d got %b->%b want distance 1",
                 i + 1, prev_v, gray_out);
      else pass_cnt++;
      prev_v = gray_out;
    end
  endtask

  // Reset, then 40 counting edges; ends at Gray(8) with one-bit steps throughout.
  task automatic test_long_run();
    @(negedge clk);
    reset   = 1'b0;
    mdl_bin = 4'd0;
    @(posedge clk);
    #1;
    prev_v = gray_out;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      reset   = 1'b1;
      mdl_bin = mdl_bin + 4'd1;
      exp_q.push_back(gray_of(mdl_bin));
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      if (gray_out !== exp_v) begin
        total_cnt++;
        $display("FAIL long_run step%0d got %b want %b", i + 1, gray_out, exp_v);
      end
      if ($countones(gray_out ^ prev_v) != 1) begin
        total_cnt++;
        $display("FAIL long_run_onebit step%0d got %b->%b want distance 1",
                 i + 1, prev_v, gray_out);
      end
      prev_v = gray_out;
    end
    total_cnt++;
    if (gray_out !== 4'b1100)
      $display("FAIL long_run_final got %b want %b", gray_out, 4'b1100);
    else pass_cnt++;
  endtask

  // Count to 0111, reset for one edge, then resume from 0001.
  task automatic test_mid_reset();
    @(negedge clk);
    reset   = 1'b0;
    mdl_bin = 4'd0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
    end
    #1;
    total_cnt++;
    if (gray_out !== 4'b0111) $display("FAIL mid_count got %b want %b", gray_out, 4'b0111);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(4'b0000);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (gray_out !== exp_v) $display("FAIL mid_reset got %b want %b", gray_out, exp_v);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(4'b0001);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (gray_out !== exp_v) $display("FAIL mid_resume got %b want %b", gray_out, exp_v);
    else pass_cnt++;
    mdl_bin = 4'd1;
  endtask

  // A reset pulse that misses every rising edge must not disturb counting.
  task automatic test_sync_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset   = 1'b1;
      mdl_bin = mdl_bin + 4'd1;
      @(posedge clk);
    end
    #1;
    prev_v = gray_out;
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (gray_out !== prev_v) $display("FAIL glitch_hold got %b want %b", gray_out, prev_v);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      mdl_bin = mdl_bin + 4'd1;
      exp_q.push_back(gray_of(mdl_bin));
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (gray_out !== exp_v)
        $display("FAIL glitch_continue%0d got %b want %b", i, gray_out, exp_v);
      else pass_cnt++;
    end
  endtask

  // 100 edges against a bench binary counter, with one check per edge.
  task automatic test_ref_model();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      reset   = 1'b1;
      mdl_bin = mdl_bin + 4'd1;
      exp_q.push_back(gray_of(mdl_bin));
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (gray_out !== exp_v)
        $display("FAIL ref_model edge%0d got %b want %b", i, gray_out, exp_v);
      else pass_cnt++;
    end
  endtask

  initial begin
    seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    reset   = 1'b0;
    mdl_bin = 4'd0;
    test_reset();
    test_full_cycle();
    test_long_run();
    test_mid_reset();
    test_sync_reset();
    test_ref_model();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
